// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: CPU request/response and memory-controller command signals of the load/store unit
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_cmd_start;
    logic        mem_cmd_write;
    logic        mem_cmd_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rdata_valid;
    logic [31:0] mem_wdata;

    modport master (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  mem_cmd_ready, mem_rdata, mem_rdata_valid,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        output mem_cmd_ready, mem_rdata, mem_rdata_valid,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I load/store front-end with sub-word extension and read-modify-write stores
module mem_access_unit (
    input  logic              clk,
    input  logic              reset,
    mem_access_unit_if.master bus
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} state_t;

    state_t      r_state, w_next;
    logic        r_write, r_fault;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic        w_accept, w_rdv, w_illegal, w_misal, w_fault;
    logic [4:0]  w_sh;
    logic [15:0] w_lane;
    logic [31:0] w_mask, w_load, w_merge;

    assign w_accept  = r_state == IDLE && bus.req_valid;
    assign w_rdv     = r_state == RD_WAIT && bus.mem_rdata_valid;
    assign w_illegal = bus.req_write ? bus.req_funct3 > 3'd2
                                     : bus.req_funct3 == 3'd3 || bus.req_funct3 > 3'd5;
    assign w_misal   = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                       (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
    assign w_fault   = w_illegal || w_misal;

    // byte lane of the access within the fetched word
    assign w_sh    = {r_addr[1:0], 3'b000};
    assign w_lane  = 16'(bus.mem_rdata >> w_sh);
    assign w_load  = r_funct3 == 3'b000 ? {{24{w_lane[7]}}, w_lane[7:0]} :
                     r_funct3 == 3'b001 ? {{16{w_lane[15]}}, w_lane} :
                     r_funct3 == 3'b100 ? {24'd0, w_lane[7:0]} :
                     r_funct3 == 3'b101 ? {16'd0, w_lane} : bus.mem_rdata;
    assign w_mask  = (r_funct3[1:0] == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << w_sh;
    assign w_merge = (bus.mem_rdata & ~w_mask) | ((r_wdata << w_sh) & w_mask);

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.req_valid)
                         w_next = w_fault ? RESP :
                                  (bus.req_write && bus.req_funct3 == 3'b010) ? WR_REQ : RD_REQ;
            RD_REQ:  if (bus.mem_cmd_ready) w_next = RD_WAIT;
            RD_WAIT: if (bus.mem_rdata_valid) w_next = r_write ? WR_REQ : RESP;
            WR_REQ:  if (bus.mem_cmd_ready) w_next = RESP;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready     = r_state == IDLE;
        bus.resp_valid    = r_state == RESP;
        bus.resp_rdata    = r_state == RESP ? r_rdata : 32'd0;
        bus.resp_fault    = r_state == RESP && r_fault;
        bus.mem_cmd_start = r_state == RD_REQ || r_state == WR_REQ;
        bus.mem_cmd_write = r_state == WR_REQ;
        bus.mem_addr      = {r_addr[31:2], 2'b00};
        bus.mem_wdata     = r_wdata;
    end

    // r_wdata becomes the merged word once the read half of a sub-word store returns
    always_ff @(posedge clk) begin
        if (reset) begin
            r_write  <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_fault  <= 1'b0;
        end else if (w_accept) begin
            r_write  <= bus.req_write;
            r_funct3 <= bus.req_funct3;
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
            r_rdata  <= 32'd0;
            r_fault  <= w_fault;
        end else if (w_rdv) begin
            if (r_write)
                r_wdata <= w_merge;
            else
                r_rdata <= w_load;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized bench against a byte-addressed reference model of RV32I loads/stores
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_access_unit_if bif();
    mem_access_unit dut (.clk(clk), .reset(reset), .bus(bif));

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [256];
    logic [7:0]  ref_b [1024];
    int rdy_dly = 0, rd_lat = 1, n_rd = 0, n_wr = 0, unstable = 0;
    int wait_cnt = 0, pend = -1;
    logic acc = 1'b0, in_cmd = 1'b0, cmd_w = 1'b0;
    logic [31:0] a0 = 32'd0, d0 = 32'd0, pend_data = 32'd0, last_addr = 32'd0;

    // memory controller: ready after rdy_dly cycles, read data rd_lat cycles after accept
    initial begin
        bif.mem_cmd_ready = 1'b0;
        bif.mem_rdata_valid = 1'b0;
        bif.mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (acc) begin
                acc = 1'b0;
                bif.mem_cmd_ready = 1'b0;
                last_addr = a0;
                if (cmd_w) begin
                    mem[a0[9:2]] = d0;
                    n_wr++;
                end else begin
                    n_rd++;
                    pend_data = mem[a0[9:2]];
                    pend = rd_lat - 1;
                end
            end
            bif.mem_rdata_valid = 1'b0;
            bif.mem_rdata = $urandom;
            if (pend == 0) begin
                bif.mem_rdata_valid = 1'b1;
                bif.mem_rdata = pend_data;
                pend = -1;
            end else if (pend > 0) pend--;
            if (bif.mem_cmd_start) begin
                if (!in_cmd) begin
                    in_cmd = 1'b1;
                    a0 = bif.mem_addr;
                    d0 = bif.mem_wdata;
                    cmd_w = bif.mem_cmd_write;
                    wait_cnt = 0;
                end else if (bif.mem_addr !== a0 || bif.mem_cmd_write !== cmd_w ||
                             (cmd_w && bif.mem_wdata !== d0)) unstable++;
                if (wait_cnt >= rdy_dly) begin
                    bif.mem_cmd_ready = 1'b1;
                    acc = 1'b1;
                    in_cmd = 1'b0;
                end else wait_cnt++;
            end else in_cmd = 1'b0;
        end
    end

    task automatic preset(input logic [31:0] a, input logic [31:0] w);
        mem[a[9:2]] = w;
        for (int i = 0; i < 4; i++) ref_b[{a[9:2], 2'b00} + i] = w[8*i +: 8];
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_b[{a[9:2], 2'b00} + i];
        return w;
    endfunction

    // expected result, command counts and latency from the access rules alone
    function automatic void ref_exec(input logic w, input logic [2:0] f3, input logic [31:0] a, d,
                                     output logic [31:0] rd, output logic flt,
                                     output int nr, output int nw, output int lat);
        int size, base;
        longint v;
        logic legal;
        legal = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size = 1 << f3[1:0];
        base = int'(a[9:0]);
        flt = !legal || (int'(a[1:0]) % size != 0);
        rd = 32'd0; nr = 0; nw = 0; lat = 1;
        if (flt) return;
        if (!w) begin
            v = 0;
            for (int i = 0; i < size; i++) v += longint'(ref_b[base + i]) << (8 * i);
            if (!f3[2] && size < 4 && v >= (64'sd1 << (8 * size - 1))) v -= (64'sd1 << (8 * size));
            rd = v[31:0];
            nr = 1;
            lat = (rdy_dly + 1) + rd_lat + 1;
        end else begin
            for (int i = 0; i < size; i++) ref_b[base + i] = d[8*i +: 8];
            nw = 1;
            nr = size < 4 ? 1 : 0;
            lat = size < 4 ? 2 * (rdy_dly + 1) + rd_lat + 1 : rdy_dly + 2;
        end
    endfunction

    // called at a negedge with the unit idle; returns at a negedge with the unit idle
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a, d,
                          output logic [31:0] rd, output logic flt, output int lat,
                          output logic rdy_ok, output logic pulse_ok);
        rdy_ok = bif.req_ready;
        bif.req_valid = 1'b1;
        bif.req_write = w;
        bif.req_funct3 = f3;
        bif.req_addr = a;
        bif.req_wdata = d;
        lat = 0;
        do begin
            @(negedge clk);
            bif.req_valid = 1'b0;
            bif.req_addr = $urandom;
            bif.req_wdata = $urandom;
            lat++;
        end while (!bif.resp_valid && lat < 200);
        rd = bif.resp_rdata;
        flt = bif.resp_fault;
        rdy_ok = rdy_ok && !bif.req_ready;
        @(negedge clk);
        pulse_ok = !bif.resp_valid && bif.req_ready;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({bif.req_ready, bif.resp_valid, bif.resp_fault, bif.mem_cmd_start, bif.mem_cmd_write} !== 5'b10000) begin errors++; $display("FAIL reset_flags got %b exp 10000", {bif.req_ready, bif.resp_valid, bif.resp_fault, bif.mem_cmd_start, bif.mem_cmd_write}); end
        checks++; if (bif.resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", bif.resp_rdata); end
        checks++; if (bif.mem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", bif.mem_addr); end
        checks++; if (bif.mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h exp 0", bif.mem_wdata); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic w; logic [2:0] f3; logic [31:0] a, d, init, exp_rd, exp_word; int exp_lat;
    } dcase_t;

    task automatic test_directed;
        dcase_t t[8];
        logic [31:0] rd;
        logic flt, rok, pok;
        int lat, nr0, nw0;
        t[0] = '{1'b0, 3'b010, 32'h100, 32'h0, 32'h8899AABB, 32'h8899AABB, 32'h8899AABB, 3};
        t[1] = '{1'b0, 3'b000, 32'h103, 32'h0, 32'h8899AABB, 32'hFFFFFF88, 32'h8899AABB, 3};
        t[2] = '{1'b0, 3'b100, 32'h103, 32'h0, 32'h8899AABB, 32'h00000088, 32'h8899AABB, 3};
        t[3] = '{1'b0, 3'b001, 32'h102, 32'h0, 32'h8899AABB, 32'hFFFF8899, 32'h8899AABB, 3};
        t[4] = '{1'b0, 3'b101, 32'h100, 32'h0, 32'h8899AABB, 32'h0000AABB, 32'h8899AABB, 3};
        t[5] = '{1'b1, 3'b000, 32'h101, 32'h000000CC, 32'h11223344, 32'h0, 32'h1122CC44, 4};
        t[6] = '{1'b1, 3'b001, 32'h102, 32'h0000BEEF, 32'h11223344, 32'h0, 32'hBEEF3344, 4};
        t[7] = '{1'b1, 3'b010, 32'h100, 32'h12345678, 32'h11223344, 32'h0, 32'h12345678, 2};
        rdy_dly = 0;
        rd_lat = 1;
        foreach (t[i]) begin
            preset(t[i].a, t[i].init);
            nr0 = n_rd;
            nw0 = n_wr;
            do_req(t[i].w, t[i].f3, t[i].a, t[i].d, rd, flt, lat, rok, pok);
            checks++; if (rd !== t[i].exp_rd) begin errors++; $display("FAIL dir%0d_rdata got %h exp %h", i, rd, t[i].exp_rd); end
            checks++; if (flt !== 1'b0) begin errors++; $display("FAIL dir%0d_fault got %b exp 0", i, flt); end
            checks++; if (lat !== t[i].exp_lat) begin errors++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, t[i].exp_lat); end
            checks++; if (mem[t[i].a[9:2]] !== t[i].exp_word) begin errors++; $display("FAIL dir%0d_word got %h exp %h", i, mem[t[i].a[9:2]], t[i].exp_word); end
            checks++; if (last_addr !== 32'h100) begin errors++; $display("FAIL dir%0d_addr got %h exp 00000100", i, last_addr); end
            checks++; if (n_rd - nr0 !== (t[i].f3 == 3'b010 && t[i].w ? 0 : 1) || n_wr - nw0 !== (t[i].w ? 1 : 0)) begin errors++; $display("FAIL dir%0d_cmds got %0d/%0d", i, n_rd - nr0, n_wr - nw0); end
            checks++; if (!rok || !pok) begin errors++; $display("FAIL dir%0d_handshake got %b%b exp 11", i, rok, pok); end
            preset(t[i].a, mem[t[i].a[9:2]]);
        end
    endtask

    task automatic test_faults;
        logic [3:0] c[7];
        logic [31:0] ca[7];
        logic [31:0] rd, w0;
        logic flt, rok, pok;
        int lat, nr0, nw0;
        c[0] = {1'b0, 3'b010}; ca[0] = 32'h102;
        c[1] = {1'b1, 3'b001}; ca[1] = 32'h101;
        c[2] = {1'b0, 3'b011}; ca[2] = 32'h100;
        c[3] = {1'b1, 3'b100}; ca[3] = 32'h100;
        c[4] = {1'b0, 3'b101}; ca[4] = 32'h103;
        c[5] = {1'b1, 3'b010}; ca[5] = 32'h101;
        c[6] = {1'b0, 3'b111}; ca[6] = 32'h104;
        foreach (c[i]) begin
            nr0 = n_rd;
            nw0 = n_wr;
            w0 = mem[ca[i][9:2]];
            do_req(c[i][3], c[i][2:0], ca[i], 32'hA5A5A5A5, rd, flt, lat, rok, pok);
            checks++; if (flt !== 1'b1) begin errors++; $display("FAIL flt%0d_fault got %b exp 1", i, flt); end
            checks++; if (rd !== 32'd0) begin errors++; $display("FAIL flt%0d_rdata got %h exp 0", i, rd); end
            checks++; if (lat !== 1) begin errors++; $display("FAIL flt%0d_latency got %0d exp 1", i, lat); end
            checks++; if (n_rd !== nr0 || n_wr !== nw0 || mem[ca[i][9:2]] !== w0) begin errors++; $display("FAIL flt%0d_nocmd got %0d/%0d cmds exp 0/0", i, n_rd - nr0, n_wr - nw0); end
        end
    endtask

    task automatic test_stall;
        logic [31:0] rd;
        logic flt, rok, pok;
        int lat, nr0;
        rdy_dly = 5;
        rd_lat = 7;
        unstable = 0;
        preset(32'h200, 32'hCAFE1234);
        nr0 = n_rd;
        do_req(1'b0, 3'b010, 32'h200, 32'h0, rd, flt, lat, rok, pok);
        checks++; if (rd !== 32'hCAFE1234) begin errors++; $display("FAIL stall_rdata got %h exp cafe1234", rd); end
        checks++; if (lat !== 14) begin errors++; $display("FAIL stall_latency got %0d exp 14", lat); end
        checks++; if (n_rd - nr0 !== 1) begin errors++; $display("FAIL stall_reads got %0d exp 1", n_rd - nr0); end
        do_req(1'b1, 3'b001, 32'h202, 32'h5555BEEF, rd, flt, lat, rok, pok);
        checks++; if (mem[32'h200 >> 2] !== 32'hBEEF1234) begin errors++; $display("FAIL stall_sh_word got %h exp beef1234", mem[32'h200 >> 2]); end
        checks++; if (lat !== 20) begin errors++; $display("FAIL stall_sh_latency got %0d exp 20", lat); end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL stall_stable got %0d changes exp 0", unstable); end
        preset(32'h200, 32'hBEEF1234);
        rdy_dly = 0;
        rd_lat = 1;
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        logic flt, rok, pok;
        int lat;
        preset(32'h300, 32'h00000000);
        do_req(1'b1, 3'b000, 32'h302, 32'h000000F0, rd, flt, lat, rok, pok);
        do_req(1'b0, 3'b000, 32'h302, 32'h0, rd, flt, lat, rok, pok);
        checks++; if (rd !== 32'hFFFFFFF0) begin errors++; $display("FAIL b2b_lb got %h exp fffffff0", rd); end
        checks++; if (!rok || !pok) begin errors++; $display("FAIL b2b_handshake got %b%b exp 11", rok, pok); end
        do_req(1'b0, 3'b010, 32'h300, 32'h0, rd, flt, lat, rok, pok);
        checks++; if (rd !== 32'h00F00000) begin errors++; $display("FAIL b2b_lw got %h exp 00f00000", rd); end
        preset(32'h300, 32'h00F00000);
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        logic flt, rok, pok, seen;
        int lat;
        rd_lat = 6;
        bif.req_valid = 1'b1;
        bif.req_write = 1'b0;
        bif.req_funct3 = 3'b010;
        bif.req_addr = 32'h140;
        @(negedge clk);
        bif.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if ({bif.req_ready, bif.resp_valid, bif.mem_cmd_start, bif.mem_cmd_write} !== 4'b1000 || bif.mem_addr !== 32'd0 || bif.resp_rdata !== 32'd0) begin errors++; $display("FAIL midrst_outputs got %b addr %h exp 1000 addr 0", {bif.req_ready, bif.resp_valid, bif.mem_cmd_start, bif.mem_cmd_write}, bif.mem_addr); end
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | bif.resp_valid | bif.mem_cmd_start;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_quiet got %b exp 0", seen); end
        rd_lat = 1;
        preset(32'h140, 32'h0BADF00D);
        do_req(1'b0, 3'b001, 32'h142, 32'h0, rd, flt, lat, rok, pok);
        checks++; if (rd !== 32'h00000BAD || lat !== 3) begin errors++; $display("FAIL midrst_next got %h lat %0d exp 00000bad lat 3", rd, lat); end
    endtask

    task automatic test_random;
        logic [31:0] rd, erd, a, d;
        logic flt, eflt, rok, pok, w;
        logic [2:0] f3;
        int lat, elat, enr, enw, nr0, nw0;
        unstable = 0;
        for (int i = 0; i < 80; i++) begin
            rdy_dly = $urandom_range(0, 2);
            rd_lat = $urandom_range(1, 3);
            w = 1'($urandom);
            f3 = 3'($urandom);
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            d = $urandom;
            nr0 = n_rd;
            nw0 = n_wr;
            ref_exec(w, f3, a, d, erd, eflt, enr, enw, elat);
            do_req(w, f3, a, d, rd, flt, lat, rok, pok);
            checks++; if (rd !== erd) begin errors++; $display("FAIL rnd%0d_rdata got %h exp %h", i, rd, erd); end
            checks++; if (flt !== eflt) begin errors++; $display("FAIL rnd%0d_fault got %b exp %b", i, flt, eflt); end
            checks++; if (lat !== elat) begin errors++; $display("FAIL rnd%0d_latency got %0d exp %0d", i, lat, elat); end
            checks++; if (n_rd - nr0 !== enr || n_wr - nw0 !== enw) begin errors++; $display("FAIL rnd%0d_cmds got %0d/%0d exp %0d/%0d", i, n_rd - nr0, n_wr - nw0, enr, enw); end
            checks++; if (mem[a[9:2]] !== ref_word(a)) begin errors++; $display("FAIL rnd%0d_word got %h exp %h", i, mem[a[9:2]], ref_word(a)); end
            if (enr + enw > 0) begin
                checks++; if (last_addr !== {a[31:2], 2'b00}) begin errors++; $display("FAIL rnd%0d_addr got %h exp %h", i, last_addr, {a[31:2], 2'b00}); end
            end
            checks++; if (!rok || !pok) begin errors++; $display("FAIL rnd%0d_handshake got %b%b exp 11", i, rok, pok); end
        end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL rnd_stable got %0d changes exp 0", unstable); end
    endtask

    initial begin
        bif.req_valid = 1'b0;
        bif.req_write = 1'b0;
        bif.req_funct3 = 3'd0;
        bif.req_addr = 32'd0;
        bif.req_wdata = 32'd0;
        for (int i = 0; i < 256; i++) preset(32'(i * 4), $urandom);
        test_reset;
        test_directed;
        test_faults;
        test_stall;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
